lbist_boot_sequencer: RTL and testbench

Sequences the LBIST-then-boot flow for the RI5CY core wrapper. Raises `test_mode`, launches the BIST engine, and checks the `go_nogo` verdict, with timeout and bounded retry. It then drops `test_mode`, holds the core in reset for a fixed window, and releases it with fetch enabled. It sits between the system clock/reset source and the core wrapper, replacing the testbench-driven `test_mode` and core-reset sequencing with synthesizable control.

---
 rtl/lbist_seq_pkg.sv | 32 +++
 rtl/lbist_seq_cnt.sv | 36 +++
 rtl/lbist_boot_sequencer.sv | 159 +++++++++++++++
 tb/tb_lbist_boot_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbist_seq_pkg.sv
// Shared types and default constants for the LBIST boot sequencer.
package lbist_seq_pkg;

    // State encoding is exported on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_SETTLE   = 3'd3,
        S_RST_HOLD = 3'd4,
        S_RUN_CORE = 3'd5,
        S_FAIL     = 3'd6
    } lbist_seq_state_e;

    localparam int DEF_TIMEOUT_CYCLES    = 65536;
    localparam int DEF_SETTLE_CYCLES     = 2;
    localparam int DEF_RESET_WAIT_CYCLES = 4;
    localparam int DEF_MAX_RETRIES       = 1;
    localparam int DEF_BYPASS_BIST       = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A state lasting N cycles loads N-1: the exit edge is the one that sees zero.
    function automatic int load_of(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/lbist_seq_cnt.sv
// Loadable saturating down-counter shared by every timed state.
module lbist_seq_cnt #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load on request, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lbist_boot_sequencer.sv
// LBIST-then-boot sequencer: runs BIST with timeout and retry, then releases the core.
module lbist_boot_sequencer
    import lbist_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
    parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES,
    parameter int BYPASS_BIST       = DEF_BYPASS_BIST
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic                               bist_done_i,
    input  logic                               go_nogo_i,
    input  logic                               fetch_enable_i,
    output logic                               test_mode_o,
    output logic                               bist_start_o,
    output logic                               core_rst_n_o,
    output logic                               fetch_enable_o,
    output logic                               bist_pass_o,
    output logic                               bist_fail_o,
    output logic                               timeout_o,
    output logic [$clog2(MAX_RETRIES+2)-1:0]   attempts_o,
    output logic [2:0]                         state_o
);

    localparam int ATT_W = $clog2(MAX_RETRIES + 2);
    localparam int CNT_W = $clog2(max3(TIMEOUT_CYCLES, SETTLE_CYCLES, RESET_WAIT_CYCLES) + 1);

    lbist_seq_state_e state_q, state_d;
    logic             test_mode_q, test_mode_d;
    logic             bist_start_q, bist_start_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             fetch_enable_q, fetch_enable_d;
    logic             bist_pass_q, bist_pass_d;
    logic             bist_fail_q, bist_fail_d;
    logic             timeout_q, timeout_d;
    logic [ATT_W-1:0] attempts_q, attempts_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             retry_ok;
    logic             enter_run;

    lbist_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    // attempts_q already counts the attempt that just ended.
    assign retry_ok = (int'(attempts_q) <= MAX_RETRIES);

    // Next state, counter reload and registered-output values derived from the next state.
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        bist_pass_d = bist_pass_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (BYPASS_BIST != 0) ? S_RST_HOLD : S_ARM;
                end
            end
            S_ARM: begin
                if (cnt_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A done strobe wins over a timeout landing on the same edge.
                if (bist_done_i) begin
                    timeout_d = 1'b0;
                    if (go_nogo_i) begin
                        state_d     = S_SETTLE;
                        bist_pass_d = 1'b1;
                    end else begin
                        state_d = retry_ok ? S_ARM : S_FAIL;
                    end
                end else if (cnt_zero) begin
                    timeout_d = 1'b1;
                    state_d   = retry_ok ? S_ARM : S_FAIL;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_d = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_RUN_CORE;
                end
            end
            S_RUN_CORE: state_d = S_RUN_CORE;
            S_FAIL:     state_d = S_FAIL;
            default:    state_d = S_IDLE;
        endcase

        cnt_load = (state_d != state_q);
        case (state_d)
            S_ARM, S_SETTLE: cnt_load_val = CNT_W'(load_of(SETTLE_CYCLES));
            S_RUN:           cnt_load_val = CNT_W'(load_of(TIMEOUT_CYCLES));
            S_RST_HOLD:      cnt_load_val = CNT_W'(load_of(RESET_WAIT_CYCLES));
            default:         cnt_load_val = '0;
        endcase

        enter_run      = (state_d == S_RUN) && (state_q != S_RUN);
        bist_start_d   = enter_run;
        attempts_d     = attempts_q + ATT_W'(enter_run);
        test_mode_d    = (state_d == S_ARM) || (state_d == S_RUN);
        core_rst_n_d   = (state_d == S_RUN_CORE);
        fetch_enable_d = core_rst_n_d && fetch_enable_i;
        bist_fail_d    = bist_fail_q || (state_d == S_FAIL);
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            test_mode_q    <= 1'b0;
            bist_start_q   <= 1'b0;
            core_rst_n_q   <= 1'b0;
            fetch_enable_q <= 1'b0;
            bist_pass_q    <= 1'b0;
            bist_fail_q    <= 1'b0;
            timeout_q      <= 1'b0;
            attempts_q     <= '0;
        end else begin
            state_q        <= state_d;
            test_mode_q    <= test_mode_d;
            bist_start_q   <= bist_start_d;
            core_rst_n_q   <= core_rst_n_d;
            fetch_enable_q <= fetch_enable_d;
            bist_pass_q    <= bist_pass_d;
            bist_fail_q    <= bist_fail_d;
            timeout_q      <= timeout_d;
            attempts_q     <= attempts_d;
        end
    end

    assign test_mode_o    = test_mode_q;
    assign bist_start_o   = bist_start_q;
    assign core_rst_n_o   = core_rst_n_q;
    assign fetch_enable_o = fetch_enable_q;
    assign bist_pass_o    = bist_pass_q;
    assign bist_fail_o    = bist_fail_q;
    assign timeout_o      = timeout_q;
    assign attempts_o     = attempts_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_lbist_boot_sequencer.sv
// Directed bench for lbist_boot_sequencer: default, short-timeout and bypass instances.
module tb_lbist_boot_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM = 3'd1, ST_RUN = 3'd2, ST_SETTLE = 3'd3,
                           ST_RST_HOLD = 3'd4, ST_RUN_CORE = 3'd5, ST_FAIL = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_def = 1'b0, start_t16 = 1'b0, start_byp = 1'b0;
    logic done = 1'b0, go = 1'b0, fen = 1'b0;

    logic       tm_def, bs_def, crn_def, fe_def, bp_def, bf_def, to_def;
    logic [1:0] att_def;
    logic [2:0] st_def;
    logic       tm_t16, bs_t16, crn_t16, fe_t16, bp_t16, bf_t16, to_t16;
    logic [1:0] att_t16;
    logic [2:0] st_t16;
    logic       tm_byp, bs_byp, crn_byp, fe_byp, bp_byp, bf_byp, to_byp;
    logic [1:0] att_byp;
    logic [2:0] st_byp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lbist_boot_sequencer u_def (
        .clk(clk), .rst(rst), .start_i(start_def), .bist_done_i(done), .go_nogo_i(go),
        .fetch_enable_i(fen), .test_mode_o(tm_def), .bist_start_o(bs_def),
        .core_rst_n_o(crn_def), .fetch_enable_o(fe_def), .bist_pass_o(bp_def),
        .bist_fail_o(bf_def), .timeout_o(to_def), .attempts_o(att_def), .state_o(st_def)
    );

    lbist_boot_sequencer #(.TIMEOUT_CYCLES(16)) u_t16 (
        .clk(clk), .rst(rst), .start_i(start_t16), .bist_done_i(done), .go_nogo_i(go),
        .fetch_enable_i(fen), .test_mode_o(tm_t16), .bist_start_o(bs_t16),
        .core_rst_n_o(crn_t16), .fetch_enable_o(fe_t16), .bist_pass_o(bp_t16),
        .bist_fail_o(bf_t16), .timeout_o(to_t16), .attempts_o(att_t16), .state_o(st_t16)
    );

    lbist_boot_sequencer #(.BYPASS_BIST(1)) u_byp (
        .clk(clk), .rst(rst), .start_i(start_byp), .bist_done_i(done), .go_nogo_i(go),
        .fetch_enable_i(fen), .test_mode_o(tm_byp), .bist_start_o(bs_byp),
        .core_rst_n_o(crn_byp), .fetch_enable_o(fe_byp), .bist_pass_o(bp_byp),
        .bist_fail_o(bf_byp), .timeout_o(to_byp), .attempts_o(att_byp), .state_o(st_byp)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start_def = 1'b0; start_t16 = 1'b0; start_byp = 1'b0; done = 1'b0; go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tm_def !== 1'b0) begin errors++; $display("FAIL reset_test_mode got=%b exp=0", tm_def); end
        checks++; if (bs_def !== 1'b0) begin errors++; $display("FAIL reset_bist_start got=%b exp=0", bs_def); end
        checks++; if (crn_def !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n got=%b exp=0", crn_def); end
        checks++; if ({fe_def, bp_def, bf_def, to_def} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {fe_def, bp_def, bf_def, to_def}); end
        checks++; if (att_def !== 2'd0) begin errors++; $display("FAIL reset_attempts got=%0d exp=0", att_def); end
        checks++; if (st_def !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", st_def, ST_IDLE); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (st_def !== ST_IDLE) begin errors++; $display("FAIL idle_hold got=%0d exp=%0d", st_def, ST_IDLE); end
    endtask

    task automatic test_pass();
        int extra;
        int early;
        do_reset();
        fen = 1'b1;
        start_def = 1'b1;
        @(negedge clk);                      // after E0
        start_def = 1'b0;
        checks++; if (st_def !== ST_ARM) begin errors++; $display("FAIL pass_arm_state got=%0d exp=%0d", st_def, ST_ARM); end
        checks++; if (tm_def !== 1'b1) begin errors++; $display("FAIL pass_tm_at_e0 got=%b exp=1", tm_def); end
        @(negedge clk);                      // after E1
        checks++; if (bs_def !== 1'b0) begin errors++; $display("FAIL pass_bs_early got=%b exp=0", bs_def); end
        @(negedge clk);                      // after E2
        checks++; if (bs_def !== 1'b1) begin errors++; $display("FAIL pass_bs_pulse got=%b exp=1", bs_def); end
        checks++; if (att_def !== 2'd1) begin errors++; $display("FAIL pass_attempts_run got=%0d exp=1", att_def); end
        checks++; if (st_def !== ST_RUN) begin errors++; $display("FAIL pass_run_state got=%0d exp=%0d", st_def, ST_RUN); end
        extra = 0;
        for (int k = 3; k <= 11; k++) begin
            @(negedge clk);
            if (bs_def) extra++;
        end
        done = 1'b1; go = 1'b1;              // sampled at E12, ten cycles after the launch
        checks++; if (extra !== 0) begin errors++; $display("FAIL pass_bs_width got=%0d extra exp=0", extra); end
        @(negedge clk);                      // after E12
        done = 1'b0; go = 1'b0;
        checks++; if (st_def !== ST_SETTLE) begin errors++; $display("FAIL pass_settle_state got=%0d exp=%0d", st_def, ST_SETTLE); end
        checks++; if (tm_def !== 1'b0) begin errors++; $display("FAIL pass_tm_drop got=%b exp=0", tm_def); end
        checks++; if (bp_def !== 1'b1) begin errors++; $display("FAIL pass_flag got=%b exp=1", bp_def); end
        early = 0;
        for (int k = 13; k <= 17; k++) begin
            @(negedge clk);
            if (crn_def) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL pass_crn_early got=%0d exp=0", early); end
        @(negedge clk);                      // after E18 = E12+2+4
        checks++; if (crn_def !== 1'b1) begin errors++; $display("FAIL pass_crn_rise got=%b exp=1", crn_def); end
        checks++; if (st_def !== ST_RUN_CORE) begin errors++; $display("FAIL pass_final_state got=%0d exp=%0d", st_def, ST_RUN_CORE); end
        checks++; if (att_def !== 2'd1) begin errors++; $display("FAIL pass_attempts got=%0d exp=1", att_def); end
        checks++; if (fe_def !== 1'b1) begin errors++; $display("FAIL pass_fetch_en got=%b exp=1", fe_def); end
        checks++; if (bf_def !== 1'b0) begin errors++; $display("FAIL pass_no_fail got=%b exp=0", bf_def); end
        fen = 1'b0;
        @(negedge clk);
        checks++; if (fe_def !== 1'b0) begin errors++; $display("FAIL pass_fetch_follow got=%b exp=0", fe_def); end
    endtask

    task automatic test_retry();
        int pulses;
        int tmdrop;
        do_reset();
        start_def = 1'b1;
        pulses = 0; tmdrop = 0;
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            start_def = 1'b0;
            if (bs_def) pulses++;
            if (k <= 8 && !tm_def) tmdrop++;
            if (k == 5) begin
                checks++; if (st_def !== ST_ARM) begin errors++; $display("FAIL retry_rearm got=%0d exp=%0d", st_def, ST_ARM); end
            end
            if (k == 7) begin
                checks++; if (att_def !== 2'd2) begin errors++; $display("FAIL retry_att_second got=%0d exp=2", att_def); end
            end
            if (k == 4) begin done = 1'b1; go = 1'b0; end
            else if (k == 8) begin done = 1'b1; go = 1'b1; end
            else begin done = 1'b0; go = 1'b0; end
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL retry_pulses got=%0d exp=2", pulses); end
        checks++; if (tmdrop !== 0) begin errors++; $display("FAIL retry_tm_held got=%0d drops exp=0", tmdrop); end
        checks++; if (att_def !== 2'd2) begin errors++; $display("FAIL retry_attempts got=%0d exp=2", att_def); end
        checks++; if (st_def !== ST_RUN_CORE) begin errors++; $display("FAIL retry_state got=%0d exp=%0d", st_def, ST_RUN_CORE); end
        checks++; if ({bp_def, bf_def, to_def} !== 3'b100) begin errors++; $display("FAIL retry_flags got=%b exp=100", {bp_def, bf_def, to_def}); end
    endtask

    task automatic test_timeout_fail();
        int pulses;
        int crnhigh;
        do_reset();
        start_t16 = 1'b1;
        pulses = 0; crnhigh = 0;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            start_t16 = 1'b0;
            if (bs_t16) pulses++;
            if (crn_t16) crnhigh++;
            if (k == 17) begin
                checks++; if (st_t16 !== ST_RUN) begin errors++; $display("FAIL to_not_early got=%0d exp=%0d", st_t16, ST_RUN); end
            end
            if (k == 18) begin
                checks++; if ({st_t16, to_t16, tm_t16} !== {ST_ARM, 2'b11}) begin errors++; $display("FAIL to_first got=%0d/%b/%b exp=1/1/1", st_t16, to_t16, tm_t16); end
            end
            if (k == 35) begin
                checks++; if (st_t16 !== ST_RUN) begin errors++; $display("FAIL to_second_run got=%0d exp=%0d", st_t16, ST_RUN); end
            end
        end
        checks++; if (st_t16 !== ST_FAIL) begin errors++; $display("FAIL to_fail_state got=%0d exp=%0d", st_t16, ST_FAIL); end
        checks++; if ({bf_t16, to_t16, bp_t16} !== 3'b110) begin errors++; $display("FAIL to_flags got=%b exp=110", {bf_t16, to_t16, bp_t16}); end
        checks++; if ({crn_t16, tm_t16} !== 2'b00) begin errors++; $display("FAIL to_outputs got=%b exp=00", {crn_t16, tm_t16}); end
        checks++; if (att_t16 !== 2'd2) begin errors++; $display("FAIL to_attempts got=%0d exp=2", att_t16); end
        checks++; if (pulses !== 2 || crnhigh !== 0) begin errors++; $display("FAIL to_pulses got=%0d,%0d exp=2,0", pulses, crnhigh); end
        start_t16 = 1'b1; done = 1'b1; go = 1'b1;
        repeat (3) @(negedge clk);
        start_t16 = 1'b0; done = 1'b0; go = 1'b0;
        checks++; if (st_t16 !== ST_FAIL) begin errors++; $display("FAIL to_terminal got=%0d exp=%0d", st_t16, ST_FAIL); end
    endtask

    task automatic test_done_timeout();
        do_reset();
        start_t16 = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            start_t16 = 1'b0;
            if (k == 18) begin
                checks++; if (to_t16 !== 1'b1) begin errors++; $display("FAIL dt_first_timeout got=%b exp=1", to_t16); end
            end
            if (k == 35) begin done = 1'b1; go = 1'b1; end
            else begin done = 1'b0; go = 1'b0; end
        end
        checks++; if (st_t16 !== ST_SETTLE) begin errors++; $display("FAIL dt_state got=%0d exp=%0d", st_t16, ST_SETTLE); end
        checks++; if ({bp_t16, to_t16, bf_t16} !== 3'b100) begin errors++; $display("FAIL dt_flags got=%b exp=100", {bp_t16, to_t16, bf_t16}); end
        checks++; if (att_t16 !== 2'd2) begin errors++; $display("FAIL dt_attempts got=%0d exp=2", att_t16); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_def = 1'b1;
        @(negedge clk);
        start_def = 1'b0;
        repeat (2) @(negedge clk);           // after E2: RUN with launch pulse high
        checks++; if ({st_def, bs_def} !== {ST_RUN, 1'b1}) begin errors++; $display("FAIL ar_pre got=%0d/%b exp=2/1", st_def, bs_def); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({tm_def, bs_def, crn_def, fe_def, bp_def, bf_def, to_def} !== 7'b0) begin errors++; $display("FAIL ar_outputs got=%b exp=0000000", {tm_def, bs_def, crn_def, fe_def, bp_def, bf_def, to_def}); end
        checks++; if ({att_def, st_def} !== {2'd0, ST_IDLE}) begin errors++; $display("FAIL ar_att_state got=%0d/%0d exp=0/0", att_def, st_def); end
        @(negedge clk);
        rst = 1'b0;
        start_def = 1'b1;
        @(negedge clk);
        start_def = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({att_def, bs_def, st_def} !== {2'd1, 1'b1, ST_RUN}) begin errors++; $display("FAIL ar_restart got=%0d/%b/%0d exp=1/1/2", att_def, bs_def, st_def); end
    endtask

    task automatic test_bypass();
        int pulses;
        int tmhigh;
        do_reset();
        start_byp = 1'b1;
        pulses = 0; tmhigh = 0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start_byp = 1'b0;
            if (bs_byp) pulses++;
            if (tm_byp) tmhigh++;
            if (k == 0) begin
                checks++; if (st_byp !== ST_RST_HOLD) begin errors++; $display("FAIL byp_state got=%0d exp=%0d", st_byp, ST_RST_HOLD); end
            end
            if (k == 3) begin
                checks++; if (crn_byp !== 1'b0) begin errors++; $display("FAIL byp_crn_early got=%b exp=0", crn_byp); end
            end
        end
        checks++; if ({crn_byp, st_byp} !== {1'b1, ST_RUN_CORE}) begin errors++; $display("FAIL byp_release got=%b/%0d exp=1/5", crn_byp, st_byp); end
        checks++; if (pulses !== 0 || tmhigh !== 0) begin errors++; $display("FAIL byp_no_bist got=%0d,%0d exp=0,0", pulses, tmhigh); end
        checks++; if ({att_byp, bp_byp} !== 3'b000) begin errors++; $display("FAIL byp_flags got=%b exp=000", {att_byp, bp_byp}); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_retry();
        test_timeout_fail();
        test_done_timeout();
        test_async_reset();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
